// File: rtl/trading_pkg.sv
// Shared constants, frame layout and FSM encoding for the trade transmit path.
// The IPv4 header checksum helper is here so the header constants live in one place.
package trading_pkg;

   localparam int HDR_LEN     = 42;
   localparam int PAYLOAD_LEN = 4;
   localparam int FRAME_LEN   = HDR_LEN + PAYLOAD_LEN;
   localparam int IDX_W       = $clog2(FRAME_LEN);

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [7:0]  IP_TOS         = 8'h00;
   localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam logic [15:0] UDP_LEN        = 16'(8 + PAYLOAD_LEN);
   localparam logic [15:0] IP_TOTAL_LEN   = 16'(20 + 8 + PAYLOAD_LEN);
   localparam logic [15:0] UDP_CSUM       = 16'h0000;

   localparam int OFF_DST_MAC   = 0;
   localparam int OFF_SRC_MAC   = 6;
   localparam int OFF_ETHERTYPE = 12;
   localparam int OFF_IP_VER    = 14;
   localparam int OFF_IP_TOS    = 15;
   localparam int OFF_IP_LEN    = 16;
   localparam int OFF_IP_ID     = 18;
   localparam int OFF_IP_FLAGS  = 20;
   localparam int OFF_IP_TTL    = 22;
   localparam int OFF_IP_PROTO  = 23;
   localparam int OFF_IP_CSUM   = 24;
   localparam int OFF_SRC_IP    = 26;
   localparam int OFF_DST_IP    = 30;
   localparam int OFF_SRC_PORT  = 34;
   localparam int OFF_DST_PORT  = 36;
   localparam int OFF_UDP_LEN   = 38;
   localparam int OFF_UDP_CSUM  = 40;
   localparam int OFF_PAYLOAD   = 42;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND
   } tx_state_t;

   // Nine non-zero header words summed wide, carries folded twice, then inverted.
   function automatic logic [15:0] ip_checksum(input logic [15:0] id,
                                               input logic [7:0]  ttl,
                                               input logic [31:0] src_ip,
                                               input logic [31:0] dst_ip);
      logic [19:0] sum;
      sum = 20'({IP_VER_IHL, IP_TOS}) + 20'(IP_TOTAL_LEN) + 20'(id) +
            20'(IP_FLAGS_DF) + 20'({ttl, IP_PROTO_UDP}) +
            20'(src_ip[31:16]) + 20'(src_ip[15:0]) +
            20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
      sum = 20'(sum[15:0]) + 20'(sum[19:16]);
      sum = 20'(sum[15:0]) + 20'(sum[19:16]);
      return ~sum[15:0];
   endfunction

endpackage

// File: rtl/trade_tx_fifo.sv
// Synchronous trade queue with first-word-fall-through read data.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module trade_tx_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/trade_tx_packetizer.sv
// Wraps each queued 32-bit trade report in an Ethernet/IPv4/UDP frame and
// streams it byte-wise, MSB first, on an 8-bit AXI-Stream master.
module trade_tx_packetizer
   import trading_pkg::*;
#(
   parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
   parameter logic [31:0] SRC_IP     = 32'hC0A8_010A,
   parameter logic [31:0] DST_IP     = 32'hC0A8_0164,
   parameter logic [15:0] SRC_PORT   = 16'd5001,
   parameter logic [15:0] DST_PORT   = 16'd5000,
   parameter logic [7:0]  TTL        = 8'd64,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trade_valid,
   input  logic [31:0] trade_info,
   output logic [7:0]  tx_axis_tdata,
   output logic        tx_axis_tvalid,
   output logic        tx_axis_tlast,
   input  logic        tx_axis_tready,
   output logic        tx_busy,
   output logic [15:0] drop_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   tx_state_t            state;
   tx_state_t            state_next;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic [31:0]          fifo_rdata;
   logic [31:0]          payload;
   logic [15:0]          ip_id;
   logic [15:0]          frame_id;
   logic [15:0]          frame_csum;
   logic [IDX_W-1:0]     idx;
   logic                 beat;
   logic                 drop;
   logic [0:FRAME_LEN-1][7:0] frame;

   trade_tx_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (trade_valid),
      .wdata (trade_info),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign fifo_pop       = (state == ST_LOAD);
   assign drop           = trade_valid && fifo_full && !fifo_pop;
   assign tx_axis_tvalid = (state == ST_SEND);
   assign tx_axis_tlast  = tx_axis_tvalid && (idx == LAST_IDX);
   assign tx_axis_tdata  = tx_axis_tvalid ? frame[idx] : 8'h00;
   assign beat           = tx_axis_tvalid && tx_axis_tready;
   assign tx_busy        = !fifo_empty || (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (!fifo_empty) state_next = ST_LOAD;
         ST_LOAD: state_next = ST_SEND;
         ST_SEND: if (beat && tx_axis_tlast) state_next = fifo_empty ? ST_IDLE : ST_LOAD;
         default: state_next = ST_IDLE;
      endcase
   end

   // Frame fields are latched in LOAD so the byte mux sees stable inputs for the whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         payload    <= '0;
         ip_id      <= '0;
         frame_id   <= '0;
         frame_csum <= '0;
         idx        <= '0;
      end else if (state == ST_LOAD) begin
         payload    <= fifo_rdata;
         frame_id   <= ip_id;
         frame_csum <= ip_checksum(ip_id, TTL, SRC_IP, DST_IP);
         idx        <= '0;
      end else if (beat) begin
         if (tx_axis_tlast) ip_id <= ip_id + 16'd1;
         else               idx   <= idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       drop_count <= '0;
      else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
   end

   always_comb begin
      frame = '0;
      frame[OFF_DST_MAC   +: 6] = DST_MAC;
      frame[OFF_SRC_MAC   +: 6] = SRC_MAC;
      frame[OFF_ETHERTYPE +: 2] = ETHERTYPE_IPV4;
      frame[OFF_IP_VER]         = IP_VER_IHL;
      frame[OFF_IP_TOS]         = IP_TOS;
      frame[OFF_IP_LEN    +: 2] = IP_TOTAL_LEN;
      frame[OFF_IP_ID     +: 2] = frame_id;
      frame[OFF_IP_FLAGS  +: 2] = IP_FLAGS_DF;
      frame[OFF_IP_TTL]         = TTL;
      frame[OFF_IP_PROTO]       = IP_PROTO_UDP;
      frame[OFF_IP_CSUM   +: 2] = frame_csum;
      frame[OFF_SRC_IP    +: 4] = SRC_IP;
      frame[OFF_DST_IP    +: 4] = DST_IP;
      frame[OFF_SRC_PORT  +: 2] = SRC_PORT;
      frame[OFF_DST_PORT  +: 2] = DST_PORT;
      frame[OFF_UDP_LEN   +: 2] = UDP_LEN;
      frame[OFF_UDP_CSUM  +: 2] = UDP_CSUM;
      frame[OFF_PAYLOAD   +: 4] = payload;
   end

endmodule

// File: tb/tb_trade_tx_packetizer.sv
// Directed bench for trade_tx_packetizer: expected frame bytes are queued when a
// trade is driven and compared as the DUT emits them.
module tb_trade_tx_packetizer;

   logic        clk;
   logic        rst_n;
   logic        trade_valid;
   logic [31:0] trade_info;
   logic [7:0]  tx_axis_tdata;
   logic        tx_axis_tvalid;
   logic        tx_axis_tlast;
   logic        tx_axis_tready;
   logic        tx_busy;
   logic [15:0] drop_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [8:0]  exp_q[$];
   logic [15:0] exp_id;

   int          frames    = 0;
   int          bidx      = 0;
   bit          in_frame  = 0;
   int          start_cyc = 0;
   int          end_cyc   = 0;
   int          gap       = 0;
   int          strobe_cyc = 0;
   bit          prev_stall = 0;
   logic [9:0]  prev_word;
   logic [7:0]  cap [46];

   trade_tx_packetizer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .trade_valid    (trade_valid),
      .trade_info     (trade_info),
      .tx_axis_tdata  (tx_axis_tdata),
      .tx_axis_tvalid (tx_axis_tvalid),
      .tx_axis_tlast  (tx_axis_tlast),
      .tx_axis_tready (tx_axis_tready),
      .tx_busy        (tx_busy),
      .drop_count     (drop_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ones' complement sum with end-around carry after every word
   function automatic logic [15:0] model_csum(input logic [15:0] id);
      logic [15:0] w [10];
      logic [16:0] acc;
      w = '{16'h4500, 16'h0020, id, 16'h4000, 16'h4011, 16'h0000,
            16'hC0A8, 16'h010A, 16'hC0A8, 16'h0164};
      acc = '0;
      for (int i = 0; i < 10; i++) begin
         acc = {1'b0, acc[15:0]} + {1'b0, w[i]};
         acc = {1'b0, acc[15:0]} + {16'h0, acc[16]};
      end
      return ~acc[15:0];
   endfunction

   function automatic void push_frame(input logic [31:0] t, input logic [15:0] id);
      logic [367:0] f;
      f = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h4500, 16'h0020,
           id, 16'h4000, 16'h4011, model_csum(id), 32'hC0A8_010A, 32'hC0A8_0164,
           16'h1389, 16'h1388, 16'h000C, 16'h0000, t};
      for (int i = 0; i < 46; i++) exp_q.push_back({(i == 45), f[367 - 8*i -: 8]});
   endfunction

   // driver: call at a negedge; returns at the following negedge
   task automatic send_trade(input logic [31:0] t, input bit accept);
      trade_valid = 1'b1;
      trade_info  = t;
      if (accept) begin
         push_frame(t, exp_id);
         exp_id = exp_id + 16'd1;
      end
      @(posedge clk);
      #1 strobe_cyc = cyc;
      @(negedge clk);
      trade_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int max_cyc);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tx_busy) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n < max_cyc), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      exp_id = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // scoreboard / protocol monitor
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_n) begin
         bidx       = 0;
         in_frame   = 0;
         prev_stall = 0;
      end else begin
         if (prev_stall)
            check("stall_hold", 32'({tx_axis_tvalid, tx_axis_tlast, tx_axis_tdata}), 32'(prev_word));
         if (in_frame) check("no_bubble", 32'(tx_axis_tvalid), 32'd1);
         if (tx_axis_tvalid && !in_frame) begin
            in_frame  = 1;
            gap       = cyc - end_cyc;
            start_cyc = cyc;
         end
         if (tx_axis_tvalid && tx_axis_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", 32'({tx_axis_tlast, tx_axis_tdata}), 32'h1FF);
            end else begin
               e = exp_q.pop_front();
               check("frame_byte", 32'({tx_axis_tlast, tx_axis_tdata}), 32'(e));
            end
            if (bidx < 46) cap[bidx] = tx_axis_tdata;
            if (tx_axis_tlast) begin
               bidx     = 0;
               in_frame = 0;
               end_cyc  = cyc;
               frames++;
            end else begin
               bidx++;
            end
         end
         prev_stall = tx_axis_tvalid && !tx_axis_tready;
         prev_word  = {tx_axis_tvalid, tx_axis_tlast, tx_axis_tdata};
      end
   end

   initial begin
      int n;
      int f0;
      rst_n          = 1'b0;
      trade_valid    = 1'b0;
      trade_info     = '0;
      tx_axis_tready = 1'b1;
      exp_id         = '0;

      // reset state
      #3;
      check("rst_tvalid", 32'(tx_axis_tvalid), 32'd0);
      check("rst_tlast",  32'(tx_axis_tlast),  32'd0);
      check("rst_tdata",  32'(tx_axis_tdata),  32'd0);
      check("rst_busy",   32'(tx_busy),        32'd0);
      check("rst_drops",  32'(drop_count),     32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // single trade, tready high
      @(negedge clk);
      send_trade(32'h0001_8001, 1'b1);
      wait_drain("t1_drain", 200);
      check("t1_frames",  32'(frames), 32'd1);
      check("t1_latency", 32'(start_cyc - strobe_cyc), 32'd2);
      check("t1_id_hi",   32'(cap[18]), 32'h00);
      check("t1_id_lo",   32'(cap[19]), 32'h00);
      check("t1_csum_hi", 32'(cap[24]), 32'hB7);
      check("t1_csum_lo", 32'(cap[25]), 32'h0E);
      check("t1_pay0",    32'(cap[42]), 32'h00);
      check("t1_pay1",    32'(cap[43]), 32'h01);
      check("t1_pay2",    32'(cap[44]), 32'h80);
      check("t1_pay3",    32'(cap[45]), 32'h01);
      check("t1_idle_busy", 32'(tx_busy), 32'd0);

      // two trades on consecutive cycles, from a fresh reset
      do_reset();
      @(negedge clk);
      f0 = frames;
      send_trade(32'h0001_8001, 1'b1);
      send_trade(32'h00FF_000A, 1'b1);
      wait_drain("t2_drain", 300);
      check("t2_frames",  32'(frames - f0), 32'd2);
      check("t2_gap",     32'(gap), 32'd2);
      check("t2_id_hi",   32'(cap[18]), 32'h00);
      check("t2_id_lo",   32'(cap[19]), 32'h01);
      check("t2_csum_hi", 32'(cap[24]), 32'hB7);
      check("t2_csum_lo", 32'(cap[25]), 32'h0D);
      check("t2_pay0",    32'(cap[42]), 32'h00);
      check("t2_pay1",    32'(cap[43]), 32'hFF);
      check("t2_pay2",    32'(cap[44]), 32'h00);
      check("t2_pay3",    32'(cap[45]), 32'h0A);

      // random back-pressure during a frame
      @(negedge clk);
      send_trade(32'hDEAD_BEEF, 1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         #2 tx_axis_tready = ($urandom_range(0, 2) != 0);
         n++;
      end
      @(posedge clk);
      #2 tx_axis_tready = 1'b1;
      wait_drain("t3_drain", 200);

      // overflow: one frame stalled in flight, then 11 pushes into the queue
      @(posedge clk);
      #2 tx_axis_tready = 1'b0;
      @(negedge clk);
      f0 = frames;
      send_trade(32'hA000_0000, 1'b1);
      n = 0;
      while (!tx_axis_tvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4_in_flight", 32'(tx_axis_tvalid), 32'd1);
      for (int i = 0; i < 11; i++) send_trade(32'hA000_0001 + 32'(i), (i < 8));
      check("t4_drops", 32'(drop_count), 32'd3);
      check("t4_busy",  32'(tx_busy), 32'd1);
      check("t4_full",  32'(dut.fifo_full), 32'd1);
      @(posedge clk);
      #2 tx_axis_tready = 1'b1;
      wait_drain("t4_drain", 1000);
      check("t4_frames", 32'(frames - f0), 32'd9);
      check("t4_drops_kept", 32'(drop_count), 32'd3);

      // asynchronous reset in the middle of a frame
      @(negedge clk);
      send_trade(32'h1234_5678, 1'b1);
      n = 0;
      while (bidx != 20 && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("t5_reached_20", 32'(bidx), 32'd20);
      rst_n = 1'b0;
      #1;
      check("t5_tvalid", 32'(tx_axis_tvalid), 32'd0);
      check("t5_tlast",  32'(tx_axis_tlast),  32'd0);
      check("t5_drops",  32'(drop_count),     32'd0);
      check("t5_busy",   32'(tx_busy),        32'd0);
      exp_q.delete();
      exp_id = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_trade(32'h0BAD_F00D, 1'b1);
      wait_drain("t5_drain", 200);
      check("t5_id_hi", 32'(cap[18]), 32'h00);
      check("t5_id_lo", 32'(cap[19]), 32'h00);

      // ID wrap 0xFFFF -> 0x0000
      @(negedge clk);
      force dut.ip_id = 16'hFFFF;
      @(negedge clk);
      release dut.ip_id;
      exp_id = 16'hFFFF;
      send_trade(32'h5555_AAAA, 1'b1);
      wait_drain("t6_drain_a", 200);
      check("t6_id_hi",   32'(cap[18]), 32'hFF);
      check("t6_id_lo",   32'(cap[19]), 32'hFF);
      check("t6_csum_hi", 32'(cap[24]), 32'hB7);
      check("t6_csum_lo", 32'(cap[25]), 32'h0E);
      @(negedge clk);
      send_trade(32'h0000_0001, 1'b1);
      wait_drain("t6_drain_b", 200);
      check("t6_wrap_hi", 32'(cap[18]), 32'h00);
      check("t6_wrap_lo", 32'(cap[19]), 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
